// File: rtl/ml_mem_arbiter_if.sv
// External-memory port bundle: the arbiter drives it as master and the memory
// answers as slave.
interface ml_mem_arbiter_if;
  logic [31:0] ext_mem_addr;
  logic [31:0] ext_mem_data_out;
  logic        ext_mem_we;
  logic        ext_mem_re;
  logic [31:0] ext_mem_data_in;
  logic        ext_mem_ready;

  modport master (
    output ext_mem_addr, ext_mem_data_out, ext_mem_we, ext_mem_re,
    input  ext_mem_data_in, ext_mem_ready
  );

  modport slave (
    input  ext_mem_addr, ext_mem_data_out, ext_mem_we, ext_mem_re,
    output ext_mem_data_in, ext_mem_ready
  );
endinterface

// File: rtl/ml_mem_arbiter.sv
// Round-robin arbiter and burst sequencer for the shared external-memory port.
// Define MEMARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
//
// state | meaning
// IDLE  | no owner; arbitrate among requesters
// BURST | issuing word beats for the granted requester
// FLUSH | last strobe is on the port
// DONE  | burst_done pulse; release grant, advance pointer
module ml_mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_we,
  input  logic [NUM_REQ*32-1:0]    req_addr,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*32-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       beat_ack,
  output logic [31:0]              rdata,
  output logic [NUM_REQ-1:0]       rvalid,
  output logic [NUM_REQ-1:0]       burst_done,
  output logic                     busy,
  ml_mem_arbiter_if.master         mem
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, BURST, FLUSH, DONE} state_t;
  state_t state_q, state_d;

  logic [31:0]      addr_a  [NUM_REQ];
  logic [31:0]      wdata_a [NUM_REQ];
  logic [LEN_W-1:0] len_a   [NUM_REQ];

  logic [IDX_W-1:0]   rr_ptr, widx, pick;
  logic [IDX_W:0]     sum;
  logic               pick_vld;
  logic [NUM_REQ-1:0] grant_vec;
  logic [31:0]        addr_q;
  logic [LEN_W-1:0]   beats_left;
  logic               we_q;
  logic               issue;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[32*i +: 32];
    assign wdata_a[i] = req_wdata[32*i +: 32];
    assign len_a[i]   = req_len[LEN_W*i +: LEN_W];
  end

  // First requester at or above the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    sum      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      if (!pick_vld && req[sum[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick     = sum[IDX_W-1:0];
      end
    end
    grant_vec = NUM_REQ'(1) << pick;
  end

`ifdef MEMARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (state_q == DONE) begin
      rr_ptr <= (widx == IDX_W'(NUM_REQ-1)) ? '0 : widx + IDX_W'(1);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    beat_ack = '0;
    issue    = (state_q == BURST) && (beats_left != '0) && mem.ext_mem_ready;
    case (state_q)
      IDLE:  if (pick_vld) state_d = (len_a[pick] == '0) ? DONE : BURST;
      BURST: if (issue) begin
               beat_ack = gnt;
               if (beats_left == LEN_W'(1)) state_d = FLUSH;
             end
      FLUSH: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt                  <= '0;
      widx                 <= '0;
      addr_q               <= '0;
      beats_left           <= '0;
      we_q                 <= 1'b0;
      burst_done           <= '0;
      rdata                <= '0;
      rvalid               <= '0;
      mem.ext_mem_addr     <= '0;
      mem.ext_mem_data_out <= '0;
      mem.ext_mem_we       <= 1'b0;
      mem.ext_mem_re       <= 1'b0;
    end else begin
      burst_done     <= '0;
      mem.ext_mem_we <= issue & we_q;
      mem.ext_mem_re <= issue & ~we_q;
      if (mem.ext_mem_re && mem.ext_mem_ready) begin
        rdata  <= mem.ext_mem_data_in;
        rvalid <= gnt;
      end else begin
        rvalid <= '0;
      end
      if (issue) begin
        mem.ext_mem_addr <= addr_q;
        if (we_q) mem.ext_mem_data_out <= wdata_a[widx];
        addr_q     <= addr_q + 32'd4;
        beats_left <= beats_left - LEN_W'(1);
      end
      case (state_q)
        IDLE: if (pick_vld) begin
                gnt        <= grant_vec;
                widx       <= pick;
                addr_q     <= addr_a[pick];
                beats_left <= len_a[pick];
                we_q       <= req_we[pick];
                // Zero-length bursts go straight to DONE, so the pulse starts here.
                if (len_a[pick] == '0) burst_done <= grant_vec;
              end
        FLUSH: burst_done <= gnt;
        DONE:  gnt <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ml_mem_arbiter.sv
// Scoreboard bench for ml_mem_arbiter: stimulus pushes expected port events,
// a negedge monitor pops and compares them.
module tb_ml_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req, req_we;
  logic [127:0] req_addr, req_wdata;
  logic [63:0]  req_len;
  logic [3:0]   gnt, beat_ack, rvalid, burst_done;
  logic [31:0]  rdata;
  logic         busy;

  ml_mem_arbiter_if mem_if ();

  ml_mem_arbiter #(.NUM_REQ(4), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .beat_ack(beat_ack),
    .rdata(rdata), .rvalid(rvalid), .burst_done(burst_done), .busy(busy),
    .mem(mem_if.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign mem_if.ext_mem_data_in = mem_word(mem_if.ext_mem_addr);

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } strobe_t;
  typedef struct packed { logic [3:0] who; logic [31:0] data; } rd_t;

  strobe_t    exp_st[$];
  rd_t        exp_rd[$];
  logic [3:0] exp_gnt[$];
  logic [3:0] exp_done[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event value %h, nothing expected", name, act);
  endtask

  // Monitor
  logic [3:0] gnt_prev = '0;
  strobe_t    m_st;
  rd_t        m_rd;
  logic [3:0] m_v;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_if.ext_mem_re || mem_if.ext_mem_we) begin
        if (exp_st.size() == 0) unexpected("strobe_addr", mem_if.ext_mem_addr);
        else begin
          m_st = exp_st.pop_front();
          chk("strobe_we", {31'b0, mem_if.ext_mem_we}, {31'b0, m_st.we});
          chk("strobe_re", {31'b0, mem_if.ext_mem_re}, {31'b0, ~m_st.we});
          chk("strobe_addr", mem_if.ext_mem_addr, m_st.addr);
          if (m_st.we) chk("strobe_wdata", mem_if.ext_mem_data_out, m_st.data);
        end
      end
      if (rvalid != 4'b0) begin
        if (exp_rd.size() == 0) unexpected("rvalid", {28'b0, rvalid});
        else begin
          m_rd = exp_rd.pop_front();
          chk("rvalid_who", {28'b0, rvalid}, {28'b0, m_rd.who});
          chk("rdata", rdata, m_rd.data);
        end
      end
      if (burst_done != 4'b0) begin
        if (exp_done.size() == 0) unexpected("burst_done", {28'b0, burst_done});
        else begin
          m_v = exp_done.pop_front();
          chk("burst_done_who", {28'b0, burst_done}, {28'b0, m_v});
        end
      end
      if (gnt != 4'b0 && gnt_prev == 4'b0) begin
        if (exp_gnt.size() == 0) unexpected("gnt", {28'b0, gnt});
        else begin
          m_v = exp_gnt.pop_front();
          chk("gnt_who", {28'b0, gnt}, {28'b0, m_v});
        end
      end
      gnt_prev = gnt;
    end else begin
      gnt_prev = '0;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, {28'b0, gnt}, 32'h0);
    chk({tag, "_beat_ack"}, {28'b0, beat_ack}, 32'h0);
    chk({tag, "_rvalid"}, {28'b0, rvalid}, 32'h0);
    chk({tag, "_burst_done"}, {28'b0, burst_done}, 32'h0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_addr"}, mem_if.ext_mem_addr, 32'h0);
    chk({tag, "_dout"}, mem_if.ext_mem_data_out, 32'h0);
    chk({tag, "_we_re"}, {30'b0, mem_if.ext_mem_we, mem_if.ext_mem_re}, 32'h0);
  endtask

  task automatic wait_done(input int idx);
    int n = 0;
    while (burst_done[idx] !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("burst_done_seen", {31'b0, burst_done[idx]}, 32'h1);
  endtask

  task automatic wait_any_done();
    int n = 0;
    while (burst_done == 4'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_busy", {31'b0, busy}, 32'h0);
  endtask

  task automatic push_read(input int who, input logic [31:0] addr, input int len);
    for (int b = 0; b < len; b++) begin
      exp_st.push_back('{we: 1'b0, addr: addr + 32'(4*b), data: 32'h0});
      exp_rd.push_back('{who: 4'(1 << who), data: mem_word(addr + 32'(4*b))});
    end
  endtask

  task automatic set_slot(input int i, input logic we, input logic [31:0] a, input logic [15:0] l);
    req_we[i] = we;
    req_addr[32*i +: 32] = a;
    req_len[16*i +: 16] = l;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acks, wes, cnt, wi;
    logic ack_now;
    logic bd_seen;
    int order [5];

    rst_n = 1'b0;
    req = '0; req_we = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    mem_if.ext_mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Single read, len 3 from 0x1000
    set_slot(0, 1'b0, 32'h0000_1000, 16'd3);
    exp_gnt.push_back(4'b0001);
    push_read(0, 32'h0000_1000, 3);
    exp_done.push_back(4'b0001);
    @(posedge clk); #1 req[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("grant_latency_gnt", {28'b0, gnt}, 32'h1);
    chk("grant_latency_busy", {31'b0, busy}, 32'h1);
    req[0] = 1'b0;
    wait_done(0);
    chk("done_with_last_rvalid", {28'b0, rvalid}, 32'h1);
    wait_idle();

    // Write, len 4 from 0x2000, ready low every other cycle
    set_slot(3, 1'b1, 32'h0000_2000, 16'd4);
    req_wdata[96 +: 32] = 32'hD000_0000;
    exp_gnt.push_back(4'b1000);
    for (int b = 0; b < 4; b++)
      exp_st.push_back('{we: 1'b1, addr: 32'h0000_2000 + 32'(4*b), data: 32'hD000_0000 + 32'(b)});
    exp_done.push_back(4'b1000);
    @(posedge clk); #1 req[3] = 1'b1;
    @(posedge clk); @(negedge clk);
    req[3] = 1'b0;
    acks = 0; wes = 0; cnt = 0; wi = 0;
    while (burst_done[3] !== 1'b1 && cnt < 60) begin
      ack_now = beat_ack[3];
      if (ack_now) acks++;
      if (mem_if.ext_mem_we) wes++;
      @(posedge clk); #1;
      if (ack_now) begin
        wi++;
        req_wdata[96 +: 32] = 32'hD000_0000 + 32'(wi);
      end
      mem_if.ext_mem_ready = ~mem_if.ext_mem_ready;
      @(negedge clk);
      cnt++;
    end
    chk("write_done_seen", {31'b0, burst_done[3]}, 32'h1);
    chk("write_beat_acks", acks, 32'd4);
    chk("write_we_strobes", wes, 32'd4);
    mem_if.ext_mem_ready = 1'b1;
    wait_idle();

    // Fairness: all four request len-1 reads; pointer starts at 0
`ifdef MEMARB_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 4; i++) set_slot(i, 1'b0, 32'h0000_3000 + 32'(256*i), 16'd1);
    for (int k = 0; k < 5; k++) begin
      exp_gnt.push_back(4'(1 << order[k]));
      push_read(order[k], 32'h0000_3000 + 32'(256*order[k]), 1);
      exp_done.push_back(4'(1 << order[k]));
    end
    @(posedge clk); #1 req = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      wait_any_done();
      chk("arb_order", {28'b0, burst_done}, 32'(1 << order[k]));
      if (k == 4) req = 4'b0000;
      @(negedge clk);
    end
    wait_idle();

    // Zero length on requester 2
    set_slot(2, 1'b0, 32'h0000_4000, 16'd0);
    exp_gnt.push_back(4'b0100);
    exp_done.push_back(4'b0100);
    @(posedge clk); #1 req[2] = 1'b1;
    @(posedge clk); @(negedge clk);
    req[2] = 1'b0;
    chk("zero_len_gnt", {28'b0, gnt}, 32'h4);
    chk("zero_len_done", {28'b0, burst_done}, 32'h4);
    chk("zero_len_strobes", {30'b0, mem_if.ext_mem_we, mem_if.ext_mem_re}, 32'h0);
    wait_idle();

    // Address wrap on requester 1
    set_slot(1, 1'b0, 32'hFFFF_FFFC, 16'd2);
    exp_gnt.push_back(4'b0010);
    exp_st.push_back('{we: 1'b0, addr: 32'hFFFF_FFFC, data: 32'h0});
    exp_rd.push_back('{who: 4'b0010, data: 32'hA5A5_FFFC});
    exp_st.push_back('{we: 1'b0, addr: 32'h0000_0000, data: 32'h0});
    exp_rd.push_back('{who: 4'b0010, data: 32'h5A5A_0000});
    exp_done.push_back(4'b0010);
    @(posedge clk); #1 req[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    req[1] = 1'b0;
    wait_done(1);
    wait_idle();

    // Reset during beat 2 of a len-8 read
    set_slot(0, 1'b0, 32'h0000_5000, 16'd8);
    exp_gnt.push_back(4'b0001);
    exp_st.push_back('{we: 1'b0, addr: 32'h0000_5000, data: 32'h0});
    exp_st.push_back('{we: 1'b0, addr: 32'h0000_5004, data: 32'h0});
    exp_rd.push_back('{who: 4'b0001, data: mem_word(32'h0000_5000)});
    @(posedge clk); #1 req[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midburst_reset");
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    bd_seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (burst_done != 4'b0) bd_seen = 1'b1;
    end
    chk("post_reset_busy", {31'b0, busy}, 32'h0);
    chk("post_reset_no_done", {31'b0, bd_seen}, 32'h0);

    chk("strobe_queue_empty", exp_st.size(), 32'd0);
    chk("rdata_queue_empty", exp_rd.size(), 32'd0);
    chk("gnt_queue_empty", exp_gnt.size(), 32'd0);
    chk("done_queue_empty", exp_done.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
